// File: rtl/mem_apb_pkg.sv
// Shared types and default widths for the register-bank
// memory slave and its bus requester.
package mem_apb_pkg;

  localparam int MEM_DATA_WIDTH = 8;
  localparam int MEM_ADDR_WIDTH = 5;
  localparam int MEM_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_SETUP,
    REQ_ACCESS
  } req_state_t;

endpackage

// File: rtl/mem_apb_wait_timer.sv
// Wait-state counter for the access phase: clear, saturating
// increment, and a terminal flag at TIMEOUT_CYCLES-1.
module mem_apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TOP =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES) : '0;

  logic [TW-1:0] count;

  // Count access-phase wait cycles; saturate instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != TOP) begin
      count <= count + TW'(1);
    end
  end

  assign term = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/mem_apb_requester.sv
// Bus requester: one command at a time through SETUP/ACCESS,
// answered by a single-cycle response pulse (data or timeout).
module mem_apb_requester
  import mem_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  sel,
  output logic                  enable,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata
);

  req_state_t            state, state_n;
  logic                  sel_n, enable_n, wr_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, rsp_rdata_n;
  logic                  rsp_valid_n, rsp_err_n;
  logic                  tmr_clr, tmr_inc, tmr_term;

  mem_apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .term   (tmr_term)
  );

  assign cmd_ready = (state == REQ_IDLE);

  // Next state and next value of every registered output.
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    enable_n    = enable;
    wr_n        = wr;
    addr_n      = addr;
    wdata_n     = wdata;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    unique case (state)
      REQ_IDLE: begin
        if (cmd_valid) begin
          wr_n     = cmd_wr;
          addr_n   = cmd_addr;
          wdata_n  = cmd_wdata;
          sel_n    = 1'b1;
          enable_n = 1'b0;
          state_n  = REQ_SETUP;
        end
      end
      REQ_SETUP: begin
        enable_n = 1'b1;
        tmr_clr  = 1'b1;
        state_n  = REQ_ACCESS;
      end
      REQ_ACCESS: begin
        if (ready || tmr_term) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = !ready;
          rsp_rdata_n = (ready && !wr) ? rdata : '0;
          sel_n       = 1'b0;
          enable_n    = 1'b0;
          wr_n        = 1'b0;
          addr_n      = '0;
          wdata_n     = '0;
          state_n     = REQ_IDLE;
        end
        tmr_inc = !ready;
      end
      default: state_n = REQ_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= REQ_IDLE;
      sel       <= 1'b0;
      enable    <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      enable    <= enable_n;
      wr        <= wr_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_mem_apb_requester.sv
// Requester bench: behavioural slave with programmable wait
// states, directed table, corner sequences and random traffic.
module tb_mem_apb_requester;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wr = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       sel, enable, wr;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic [7:0] rdata;

  int checks = 0;
  int errs = 0;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic       mem_clear = 1'b1;
  int         stall_req = 0;
  int         acc_cnt = 0;

  always #5 clk = ~clk;

  mem_apb_requester #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .sel(sel), .enable(enable), .wr(wr),
    .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata)
  );

  // Slave: ready after stall_req access cycles, async read.
  assign ready = sel && enable && (acc_cnt >= stall_req);
  assign rdata = mem[addr];

  always @(posedge clk) begin
    if (sel && enable && !ready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (sel && enable && ready && wr) begin
      mem[addr] <= wdata;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Expected outcome from the transfer rules alone.
  function automatic int exp_lat(input int s);
    return (s >= TO) ? 2 + TO : 3 + s;
  endfunction

  function automatic logic [7:0] exp_rd(input logic w,
                                        input logic [4:0] a,
                                        input int s);
    return (w || s >= TO) ? 8'h00 : ref_mem[a];
  endfunction

  task automatic model_upd(input logic w, input logic [4:0] a,
                           input logic [7:0] d, input int s);
    if (w && s < TO) ref_mem[a] = d;
  endtask

  task automatic run_cmd(input logic w, input logic [4:0] a,
                         input logic [7:0] d, input int s,
                         output logic [7:0] rd, output logic er,
                         output int lat, output int sc,
                         output int ec);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
    stall_req = s;
    cmd_valid = 1'b1;
    cmd_wr = w;
    cmd_addr = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr = 1'($urandom);
    cmd_addr = 5'($urandom);
    cmd_wdata = 8'($urandom);
    lat = 1;
    sc = 0;
    ec = 0;
    while (!rsp_valid && lat < 60) begin
      sc += int'(sel);
      ec += int'(enable);
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (!rsp_valid) lat = -1;
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 0);
    check("rsp_hold", {23'd0, rsp_err, rsp_rdata},
          {23'd0, er, rd});
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         stall;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat, sc, ec;
    logic [7:0] rq[$];
    int         acc[4];
    logic       bw[4];
    logic [4:0] ba[4];
    logic [7:0] bd[4];
    int         i, cyc, guard;
    logic       r, v, seen;

    tbl[0] = '{1'b1, 5'd5,  8'hA5, 0,  8'h00, 1'b0, 3};
    tbl[1] = '{1'b0, 5'd5,  8'h00, 0,  8'hA5, 1'b0, 3};
    tbl[2] = '{1'b0, 5'd31, 8'h00, 0,  8'h00, 1'b0, 3};
    tbl[3] = '{1'b1, 5'd3,  8'h3C, 15, 8'h00, 1'b0, 18};
    tbl[4] = '{1'b0, 5'd3,  8'h00, 16, 8'h00, 1'b1, 18};
    tbl[5] = '{1'b0, 5'd3,  8'h00, 2,  8'h3C, 1'b0, 5};
    tbl[6] = '{1'b1, 5'd3,  8'hEE, 99, 8'h00, 1'b1, 18};
    tbl[7] = '{1'b0, 5'd3,  8'h00, 0,  8'h3C, 1'b0, 3};

    for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;

    // Reset held 3 cycles; registered outputs must be 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_outs",
            {9'd0, sel, enable, wr, addr, wdata,
             rsp_valid, rsp_rdata, rsp_err}, 0);
    end
    mem_clear = 1'b0;
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 1);
    @(negedge clk);

    // Directed table, including wait-state/timeout boundary.
    for (int k = 0; k < 8; k++) begin
      run_cmd(tbl[k].wr, tbl[k].addr, tbl[k].wdata,
              tbl[k].stall, rd, er, lat, sc, ec);
      model_upd(tbl[k].wr, tbl[k].addr, tbl[k].wdata,
                tbl[k].stall);
      check($sformatf("tbl%0d_rdata", k), 32'(rd),
            32'(tbl[k].exp_rdata));
      check($sformatf("tbl%0d_err", k), 32'(er),
            32'(tbl[k].exp_err));
      check($sformatf("tbl%0d_lat", k), 32'(lat),
            32'(tbl[k].exp_lat));
      check($sformatf("tbl%0d_sel_cyc", k), 32'(sc),
            32'(tbl[k].exp_lat - 1));
      check($sformatf("tbl%0d_en_cyc", k), 32'(ec),
            32'(tbl[k].exp_lat - 2));
    end
    check("bus_idle_after_timeout",
          {30'd0, sel, enable}, 0);

    // Back-to-back with cmd_valid held high.
    bw = '{1'b1, 1'b1, 1'b0, 1'b0};
    ba = '{5'd1, 5'd2, 5'd1, 5'd2};
    bd = '{8'h11, 8'h22, 8'h00, 8'h00};
    stall_req = 0;
    i = 0;
    cyc = 0;
    cmd_valid = 1'b1;
    cmd_wr = bw[0];
    cmd_addr = ba[0];
    cmd_wdata = bd[0];
    while (rq.size() < 4 && cyc < 80) begin
      r = cmd_ready;
      v = cmd_valid;
      @(negedge clk);
      cyc++;
      if (rsp_valid) rq.push_back(rsp_rdata);
      if (r && v) begin
        acc[i] = cyc;
        i++;
        if (i < 4) begin
          cmd_wr = bw[i];
          cmd_addr = ba[i];
          cmd_wdata = bd[i];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    ref_mem[1] = 8'h11;
    ref_mem[2] = 8'h22;
    check("b2b_count", 32'(rq.size()), 4);
    if (i == 4) begin
      for (int k = 1; k < 4; k++)
        check($sformatf("b2b_gap%0d", k),
              32'(acc[k] - acc[k-1]), 3);
    end
    if (rq.size() == 4) begin
      check("b2b_rd1", 32'(rq[2]), 32'(ref_mem[1]));
      check("b2b_rd2", 32'(rq[3]), 32'(ref_mem[2]));
    end
    @(negedge clk);

    // Reset asserted mid-ACCESS: bus drops without a clock edge.
    stall_req = 5;
    cmd_valid = 1'b1;
    cmd_wr = 1'b1;
    cmd_addr = 5'd7;
    cmd_wdata = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!enable && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("midreset_reached_access", 32'(enable), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_bus_drop", {30'd0, sel, enable}, 0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("midreset_no_rsp", 32'(seen), 0);
    reset_n = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 5'd7, 8'h00, 0, rd, er, lat, sc, ec);
    check("midreset_lost_write", 32'(rd), 32'(ref_mem[7]));
    run_cmd(1'b1, 5'd7, 8'h77, 0, rd, er, lat, sc, ec);
    model_upd(1'b1, 5'd7, 8'h77, 0);
    run_cmd(1'b0, 5'd7, 8'h00, 1, rd, er, lat, sc, ec);
    check("after_reset_rd7", {23'd0, er, rd},
          {23'd0, 1'b0, ref_mem[7]});
    check("after_reset_lat", 32'(lat), 32'(exp_lat(1)));

    // Random traffic against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic       w;
      logic [4:0] a;
      logic [7:0] d, erd;
      int         s, el;
      w = 1'($urandom);
      a = 5'($urandom);
      d = 8'($urandom);
      s = ($urandom_range(0, 7) == 0) ?
          int'($urandom_range(16, 20)) :
          int'($urandom_range(0, 3));
      erd = exp_rd(w, a, s);
      el = exp_lat(s);
      run_cmd(w, a, d, s, rd, er, lat, sc, ec);
      model_upd(w, a, d, s);
      check($sformatf("rnd%0d_rdata", k), 32'(rd), 32'(erd));
      check($sformatf("rnd%0d_err", k), 32'(er),
            32'(s >= TO));
      check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(el));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

endmodule
